// File: rtl/out_uart_reporter.sv
// out_uart_reporter: prints each strobed out_val as two ASCII hex characters on an 8N1 UART line.
// Build option: define OUT_REPORT_CRLF_EN to append CR LF to every report.
package arch_defs_pkg;
    localparam int unsigned DATA_WIDTH = 8;
endpackage

module out_uart_reporter
    import arch_defs_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115_200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] out_val,
    input  logic                  out_strobe,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef OUT_REPORT_CRLF_EN
    localparam int unsigned NCHARS = 4;
`else
    localparam int unsigned NCHARS = 2;
`endif
    localparam int unsigned IW = $clog2(NCHARS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] CHAR_LAST = IW'(NCHARS - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $fatal(1, "out_uart_reporter: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_baud_cnt, w_baud_nxt;
    logic [2:0]            r_bit_idx, w_bit_nxt;
    logic [IW-1:0]         r_char_idx, w_char_nxt;
    logic [DATA_WIDTH-1:0] r_cur_val, w_cur_nxt;
    logic [DATA_WIDTH-1:0] r_pend_val, w_pend_val_nxt;
    logic                  r_pend_valid, w_pend_valid_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  w_bit_end;
    logic                  w_report_end;
    logic                  w_strobe_starts;
    logic [7:0]            w_char_byte;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0000, n}) : (8'h37 + {4'b0000, n});
    endfunction

    function automatic logic [7:0] f_char(input logic [DATA_WIDTH-1:0] val,
                                          input logic [IW-1:0]         idx);
        logic [7:0] c;
        c = f_hex(val[7:4]);
        if (idx == IW'(1)) c = f_hex(val[3:0]);
`ifdef OUT_REPORT_CRLF_EN
        else if (idx == IW'(2)) c = 8'h0D;
        else if (idx == IW'(3)) c = 8'h0A;
`endif
        return c;
    endfunction

    always_comb begin
        w_state_nxt      = r_state;
        w_baud_nxt       = r_baud_cnt;
        w_bit_nxt        = r_bit_idx;
        w_char_nxt       = r_char_idx;
        w_cur_nxt        = r_cur_val;
        w_pend_val_nxt   = r_pend_val;
        w_pend_valid_nxt = r_pend_valid;
        w_overrun_nxt    = r_overrun;
        w_strobe_starts  = 1'b0;
        w_bit_end        = (r_baud_cnt == BAUD_LAST);
        w_report_end     = (r_state == S_STOP) && w_bit_end && (r_char_idx == CHAR_LAST);

        case (r_state)
            S_IDLE: begin
                if (out_strobe) begin
                    w_strobe_starts = 1'b1;
                    w_cur_nxt       = out_val;
                    w_char_nxt      = '0;
                    w_baud_nxt      = '0;
                    w_state_nxt     = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                    else                   w_bit_nxt   = r_bit_idx + 3'd1;
                end else begin
                    w_baud_nxt = r_baud_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_char_idx != CHAR_LAST) begin
                        w_char_nxt  = r_char_idx + IW'(1);
                        w_state_nxt = S_START;
                    end else if (r_pend_valid) begin
                        w_cur_nxt        = r_pend_val;
                        w_pend_valid_nxt = 1'b0;
                        w_char_nxt       = '0;
                        w_state_nxt      = S_START;
                    end else if (out_strobe) begin
                        w_strobe_starts = 1'b1;
                        w_cur_nxt       = out_val;
                        w_char_nxt      = '0;
                        w_state_nxt     = S_START;
                    end else begin
                        w_char_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A strobe landing as pending drains refills the slot without counting as overrun.
        if (out_strobe && !w_strobe_starts) begin
            if (r_pend_valid && !w_report_end) w_overrun_nxt = 1'b1;
            w_pend_val_nxt   = out_val;
            w_pend_valid_nxt = 1'b1;
        end

        w_char_byte = f_char(w_cur_nxt, w_char_nxt);
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_char_byte[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_char_idx   <= '0;
            r_cur_val    <= '0;
            r_pend_val   <= '0;
            r_pend_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_tx         <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_baud_cnt   <= w_baud_nxt;
            r_bit_idx    <= w_bit_nxt;
            r_char_idx   <= w_char_nxt;
            r_cur_val    <= w_cur_nxt;
            r_pend_val   <= w_pend_val_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_overrun    <= w_overrun_nxt;
            r_tx         <= w_tx_nxt;
        end
    end

    assign uart_tx = r_tx;
    assign busy    = (r_state != S_IDLE);
    assign overrun = r_overrun;

endmodule
